// File: rtl/id_stage_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage's view; the master modport is the surrounding pipeline's view.
interface id_stage_if #(
    parameter int IW = 16,
    parameter int RW = 5
);
    logic [IW-1:0] i_instr;
    logic          i_valid;
    logic          o_ready;
    logic          i_flush;
    logic          o_valid;
    logic          i_ready;
    logic [RW-1:0] o_src;
    logic [RW-1:0] o_dst;
    logic [IW-1:0] o_imm;
    logic          o_lw;
    logic          o_j;
    logic          o_br;
    logic          o_bq_blt;
    logic          o_ill;
    logic [15:0]   o_stall_cnt;

    modport slave (
        input  i_instr, i_valid, i_flush, i_ready,
        output o_ready, o_valid, o_src, o_dst, o_imm,
        output o_lw, o_j, o_br, o_bq_blt, o_ill, o_stall_cnt
    );

    modport master (
        output i_instr, i_valid, i_flush, i_ready,
        input  o_ready, o_valid, o_src, o_dst, o_imm,
        input  o_lw, o_j, o_br, o_bq_blt, o_ill, o_stall_cnt
    );
endinterface

// File: rtl/id_stage.sv
// Instruction decode stage: one-entry registered output, load-use hazard interlock
// with a programmable post-load gap, and a saturating hazard-stall counter.
module id_stage #(
    parameter int IW     = 16,
    parameter int OPW    = 4,
    parameter int RW     = 5,
    parameter int SEXT   = 0,
    parameter int LU_GAP = 1
) (
    input logic       i_clk,
    input logic       i_rst,
    id_stage_if.slave bus
);

    localparam logic [OPW-1:0] OP_MOV   = OPW'(3'd0);
    localparam logic [OPW-1:0] OP_LW    = OPW'(3'd1);
    localparam logic [OPW-1:0] OP_J     = OPW'(3'd2);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(3'd3);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(3'd4);
    localparam logic [3:0]     GAP_LOAD = 4'(LU_GAP);

    // Immediate is everything above the opcode, widened back to IW bits.
    function automatic logic [IW-1:0] ext_imm(input logic [IW-1:0] instr);
        logic [IW-OPW-1:0] fld;
        fld = instr[IW-1:OPW];
        if (SEXT != 0) begin
            ext_imm = {{OPW{fld[IW-OPW-1]}}, fld};
        end else begin
            ext_imm = {{OPW{1'b0}}, fld};
        end
    endfunction

    logic [OPW-1:0] opc_s;
    logic [RW-1:0]  src_s;
    logic [RW-1:0]  dst_s;
    logic [IW-1:0]  imm_s;
    logic           dec_lw_s;
    logic           dec_j_s;
    logic           dec_br_s;
    logic           dec_bq_blt_s;
    logic           dec_ill_s;

    logic           valid_r;
    logic [RW-1:0]  src_r;
    logic [RW-1:0]  dst_r;
    logic [IW-1:0]  imm_r;
    logic           lw_r;
    logic           j_r;
    logic           br_r;
    logic           bq_blt_r;
    logic           ill_r;
    logic           lw_pend_r;
    logic [RW-1:0]  lw_tag_r;
    logic [3:0]     gap_cnt_r;
    logic [15:0]    stall_cnt_r;

    logic           valid_nxt_s;
    logic [RW-1:0]  src_nxt_s;
    logic [RW-1:0]  dst_nxt_s;
    logic [IW-1:0]  imm_nxt_s;
    logic           lw_nxt_s;
    logic           j_nxt_s;
    logic           br_nxt_s;
    logic           bq_blt_nxt_s;
    logic           ill_nxt_s;
    logic           lw_pend_nxt_s;
    logic [RW-1:0]  lw_tag_nxt_s;
    logic [3:0]     gap_cnt_nxt_s;
    logic [15:0]    stall_cnt_nxt_s;

    logic           lw_held_s;
    logic           hazard_s;
    logic           ready_s;
    logic           accept_s;
    logic           leave_s;
    logic           lw_leave_s;

    assign opc_s = bus.i_instr[OPW-1:0];
    assign src_s = bus.i_instr[OPW+RW-1:OPW];
    assign dst_s = bus.i_instr[OPW+2*RW-1:OPW+RW];
    assign imm_s = ext_imm(bus.i_instr);

    // Opcode to control-flag decode; anything outside the known set is illegal.
    always_comb begin
        dec_lw_s     = 1'b0;
        dec_j_s      = 1'b0;
        dec_br_s     = 1'b0;
        dec_bq_blt_s = 1'b0;
        dec_ill_s    = 1'b0;
        case (opc_s)
            OP_MOV: dec_ill_s = 1'b0;
            OP_LW:  dec_lw_s  = 1'b1;
            OP_J:   dec_j_s   = 1'b1;
            OP_BEQ: begin
                dec_br_s     = 1'b1;
                dec_bq_blt_s = 1'b1;
            end
            OP_BLT: dec_br_s  = 1'b1;
            default: dec_ill_s = 1'b1;
        endcase
    end

    // A jump never reads its source register, so it is exempt from the interlock.
    assign lw_held_s  = valid_r & lw_r;
    assign hazard_s   = bus.i_valid & lw_pend_r & (src_s == lw_tag_r) & (opc_s != OP_J)
                        & (lw_held_s | (gap_cnt_r != 4'd0));
    assign ready_s    = ~i_rst & ~bus.i_flush & ~hazard_s & (~valid_r | bus.i_ready);
    assign accept_s   = bus.i_valid & ready_s;
    assign leave_s    = valid_r & bus.i_ready;
    assign lw_leave_s = leave_s & lw_r;

    // Output register next state: flush wins, then a new accept, then drain, else hold.
    always_comb begin
        valid_nxt_s  = valid_r;
        src_nxt_s    = src_r;
        dst_nxt_s    = dst_r;
        imm_nxt_s    = imm_r;
        lw_nxt_s     = lw_r;
        j_nxt_s      = j_r;
        br_nxt_s     = br_r;
        bq_blt_nxt_s = bq_blt_r;
        ill_nxt_s    = ill_r;
        if (bus.i_flush) begin
            valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            valid_nxt_s  = 1'b1;
            src_nxt_s    = src_s;
            dst_nxt_s    = dst_s;
            imm_nxt_s    = imm_s;
            lw_nxt_s     = dec_lw_s;
            j_nxt_s      = dec_j_s;
            br_nxt_s     = dec_br_s;
            bq_blt_nxt_s = dec_bq_blt_s;
            ill_nxt_s    = dec_ill_s;
        end else if (leave_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Load-use tracking; the pending flag is kept while any lw still sits in the output register.
    always_comb begin
        gap_cnt_nxt_s = gap_cnt_r;
        lw_pend_nxt_s = lw_pend_r;
        lw_tag_nxt_s  = lw_tag_r;
        if (bus.i_flush) begin
            gap_cnt_nxt_s = 4'd0;
            lw_pend_nxt_s = 1'b0;
        end else begin
            if (lw_leave_s) begin
                gap_cnt_nxt_s = GAP_LOAD;
            end else if (gap_cnt_r != 4'd0) begin
                gap_cnt_nxt_s = gap_cnt_r - 4'd1;
            end else begin
                gap_cnt_nxt_s = 4'd0;
            end
            if (accept_s && dec_lw_s) begin
                lw_pend_nxt_s = 1'b1;
                lw_tag_nxt_s  = dst_s;
            end else if (lw_pend_r && (gap_cnt_nxt_s == 4'd0) && !(valid_nxt_s && lw_nxt_s)) begin
                lw_pend_nxt_s = 1'b0;
            end else begin
                lw_pend_nxt_s = lw_pend_r;
            end
        end
    end

    // Stall counter advances on every unflushed hazard cycle and sticks at all-ones.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        if (bus.i_flush) begin
            stall_cnt_nxt_s = stall_cnt_r;
        end else if (hazard_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_nxt_s = stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r     <= 1'b0;
            src_r       <= '0;
            dst_r       <= '0;
            imm_r       <= '0;
            lw_r        <= 1'b0;
            j_r         <= 1'b0;
            br_r        <= 1'b0;
            bq_blt_r    <= 1'b0;
            ill_r       <= 1'b0;
            lw_pend_r   <= 1'b0;
            lw_tag_r    <= '0;
            gap_cnt_r   <= 4'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            valid_r     <= valid_nxt_s;
            src_r       <= src_nxt_s;
            dst_r       <= dst_nxt_s;
            imm_r       <= imm_nxt_s;
            lw_r        <= lw_nxt_s;
            j_r         <= j_nxt_s;
            br_r        <= br_nxt_s;
            bq_blt_r    <= bq_blt_nxt_s;
            ill_r       <= ill_nxt_s;
            lw_pend_r   <= lw_pend_nxt_s;
            lw_tag_r    <= lw_tag_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign bus.o_ready     = ready_s;
    assign bus.o_valid     = valid_r;
    assign bus.o_src       = src_r;
    assign bus.o_dst       = dst_r;
    assign bus.o_imm       = imm_r;
    assign bus.o_lw        = lw_r;
    assign bus.o_j         = j_r;
    assign bus.o_br        = br_r;
    assign bus.o_bq_blt    = bq_blt_r;
    assign bus.o_ill       = ill_r;
    assign bus.o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: a zero-extending instance is driven from a table,
// and a sign-extending twin sees the same inputs so both immediate modes are compared.
module tb_id_stage;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    id_stage_if #(.IW(16), .RW(5)) bus_m ();
    id_stage_if #(.IW(16), .RW(5)) bus_s ();

    id_stage #(.IW(16), .OPW(4), .RW(5), .SEXT(0), .LU_GAP(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_m)
    );

    id_stage #(.IW(16), .OPW(4), .RW(5), .SEXT(1), .LU_GAP(1)) dut_s (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_s)
    );

    assign bus_s.i_instr = bus_m.i_instr;
    assign bus_s.i_valid = bus_m.i_valid;
    assign bus_s.i_flush = bus_m.i_flush;
    assign bus_s.i_ready = bus_m.i_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] instr;
        logic        fl;
        logic        ir;
        logic        e_rdy;
        logic        e_ov;
        logic [4:0]  e_flags;   // {lw, j, br, bq_blt, ill}
        logic [4:0]  e_src;
        logic [4:0]  e_dst;
        logic [15:0] e_imm;
        logic [15:0] e_imm_s;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] ins,
                         input logic f, input logic ir);
        rst           = r;
        bus_m.i_valid = v;
        bus_m.i_instr = ins;
        bus_m.i_flush = f;
        bus_m.i_ready = ir;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_chk = 0;
        n_err = 0;

        // rows: rst vld instr fl ir | rdy ov flags src dst imm imm_s stall
        vq.push_back('{1'b0, 1'b1, 16'h0213, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd0});
        vq.push_back('{1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00110, 5'd1, 5'd1, 16'h0021, 16'h0021, 16'd0});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd2, 5'd0, 16'h0002, 16'h0002, 16'd0});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd0});
        vq.push_back('{1'b0, 1'b1, 16'h0601, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd0});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd0});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd1});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd2});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd3, 5'd0, 16'h0003, 16'h0003, 16'd2});
        vq.push_back('{1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd2});
        for (int i = 0; i < 4; i++) begin
            vq.push_back('{1'b0, 1'b1, 16'h0213, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'd4, 5'd0, 16'h0004, 16'h0004, 16'd2});
        end
        vq.push_back('{1'b0, 1'b1, 16'h0213, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd4, 5'd0, 16'h0004, 16'h0004, 16'd2});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00110, 5'd1, 5'd1, 16'h0021, 16'h0021, 16'd2});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd2});
        vq.push_back('{1'b0, 1'b1, 16'h0601, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd2});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd2});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd3});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd3, 5'd0, 16'h0003, 16'h0003, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h800F, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h0601, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00001, 5'd0, 5'd0, 16'h0800, 16'hF800, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h0032, 1'b0, 1'b1, 1'b1, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h0034, 1'b0, 1'b1, 1'b0, 1'b1, 5'b01000, 5'd3, 5'd0, 16'h0003, 16'h0003, 16'd3});
        vq.push_back('{1'b0, 1'b1, 16'h0034, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd4});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00100, 5'd3, 5'd0, 16'h0003, 16'h0003, 16'd4});
        vq.push_back('{1'b0, 1'b1, 16'h0601, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd4});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd4});
        vq.push_back('{1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b1, 5'b10000, 5'd0, 5'd3, 16'h0060, 16'h0060, 16'd5});
        vq.push_back('{1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'd0, 5'd0, 16'h0000, 16'h0000, 16'd0});
        vq.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'd3, 5'd0, 16'h0003, 16'h0003, 16'd0});

        // Reset: held for two edges with a valid beq offered, which must be refused.
        drive(1'b1, 1'b1, 16'h0213, 1'b0, 1'b1);
        cyc();
        cyc();
        chk("rst ready", 32'(bus_m.o_ready), 32'd0);
        chk("rst valid", 32'(bus_m.o_valid), 32'd0);
        chk("rst flags", 32'({bus_m.o_lw, bus_m.o_j, bus_m.o_br, bus_m.o_bq_blt, bus_m.o_ill}), 32'd0);
        chk("rst src", 32'(bus_m.o_src), 32'd0);
        chk("rst dst", 32'(bus_m.o_dst), 32'd0);
        chk("rst imm", 32'(bus_m.o_imm), 32'd0);
        chk("rst imm_s", 32'(bus_s.o_imm), 32'd0);
        chk("rst stall", 32'(bus_m.o_stall_cnt), 32'd0);

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            drive(v.rst, v.vld, v.instr, v.fl, v.ir);
            #1;
            chk($sformatf("r%0d ready", k), 32'(bus_m.o_ready), 32'(v.e_rdy));
            chk($sformatf("r%0d valid", k), 32'(bus_m.o_valid), 32'(v.e_ov));
            chk($sformatf("r%0d stall", k), 32'(bus_m.o_stall_cnt), 32'(v.e_stall));
            if (v.e_ov) begin
                chk($sformatf("r%0d flags", k),
                    32'({bus_m.o_lw, bus_m.o_j, bus_m.o_br, bus_m.o_bq_blt, bus_m.o_ill}), 32'(v.e_flags));
                chk($sformatf("r%0d src", k), 32'(bus_m.o_src), 32'(v.e_src));
                chk($sformatf("r%0d dst", k), 32'(bus_m.o_dst), 32'(v.e_dst));
                chk($sformatf("r%0d imm", k), 32'(bus_m.o_imm), 32'(v.e_imm));
                chk($sformatf("r%0d imm_s", k), 32'(bus_s.o_imm), 32'(v.e_imm_s));
            end
            cyc();
        end

        // Saturation: a held lw with a dependent mov offered stalls every cycle.
        drive(1'b0, 1'b1, 16'h0601, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
        for (int i = 1; i <= 65540; i++) begin
            cyc();
            if (i == 100) begin
                chk("sat mid", 32'(bus_m.o_stall_cnt), 32'd100);
            end
        end
        chk("sat value", 32'(bus_m.o_stall_cnt), 32'h0000FFFF);
        chk("sat ready", 32'(bus_m.o_ready), 32'd0);
        chk("sat held lw", 32'({bus_m.o_valid, bus_m.o_lw}), 32'd3);
        drive(1'b0, 1'b1, 16'h0030, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        #1;
        chk("post flush stall", 32'(bus_m.o_stall_cnt), 32'h0000FFFF);
        chk("post flush valid", 32'(bus_m.o_valid), 32'd0);
        chk("post flush ready", 32'(bus_m.o_ready), 32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
